ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and consumes all of its outputs.
- Computes the ALU result, memory address, register-write destination and branch/jump resolution.
- Registers the results into EX/MEM outputs for the memory stage.
- Sends a registered PC redirect to fetch and kills the one wrong-path instruction that follows a taken redirect.

Parameters:
NBITS, 32, datapath width; only 32 is supported.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-low
i_valid  in  1  ID/EX slot holds a real instruction
i_stall  in  1  memory stage not ready; hold EX/MEM contents
i_flush  in  1  kill the instruction entering this cycle
i_pc  in  NBITS  address of the instruction
i_rd  in  5  rd field
i_rt  in  5  rt field
i_addr_offset  in  26  immediate/jump index
i_flg_equal  in  1  branch sense: 1=BEQ, 0=BNE
i_flg_mem_op  in  1  memory access
i_flg_mem_type  in  1  0=load, 1=store
i_flg_mem_size  in  2  passthrough
i_flg_unsign  in  1  passthrough
i_ALU_dst  in  2  destination: 0=rd, 1=rt, 2=r31, 3=no write
i_ALU_opcode  in  4  ALU operation
i_AGU_dst  in  1  passthrough
i_AGU_opcode  in  3  address/branch operation
i_flg_branch, i_flg_jump  in  1 each  qualify AGU ops 1 / 2-3
i_ALU_src_A, i_ALU_src_B, i_AGU_src_addr  in  NBITS each  operands
o_valid  out  1  EX/MEM slot valid
o_reg_write  out  1  register write enable
o_wr_reg  out  5  register to write
o_alu_result  out  NBITS  ALU result
o_mem_addr  out  NBITS  memory address
o_store_data  out  NBITS  equals src_B
o_flg_mem_op, o_flg_mem_type, o_flg_mem_size, o_flg_unsign, o_AGU_dst  out  as inputs  passthroughs
o_redirect  out  1  one-cycle pulse: fetch must load o_redirect_pc
o_redirect_pc  out  NBITS  redirect target

Behaviour:
- Reset (i_rst=0, asynchronous): every output is 0, including o_valid and o_redirect. The squash flag is 0.
- Latency: 1 cycle. Inputs present at edge N appear on the outputs after edge N.
- ALU opcodes (A=src_A, B=src_B):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed compare, result 0/1), 7 SLTU (unsigned compare, result 0/1).
  - 8 SLL A<<B[4:0], 9 SRL, 10 SRA (arithmetic).
  - 11 LUI {B[15:0],16'h0}.
  - 12 LINK i_pc+8.
  - 13-15 give 0.
  - Arithmetic wraps modulo 2^32; no overflow trap.
- sext16 = sign extension of offset[15:0].
- AGU opcodes:
  - 0 none.
  - 1 branch, only when i_flg_branch=1: taken if (A==B)==i_flg_equal; target = i_pc+4+(sext16<<2).
  - 2 J, only when i_flg_jump=1: target = {i_pc[31:28], offset, 2'b00}.
  - 3 JR, only when i_flg_jump=1: target = i_AGU_src_addr.
  - 4 address: o_mem_addr = i_AGU_src_addr + sext16.
  - 5-7 none. When there is no address op, o_mem_addr = 0.
- Write destination:
  - o_wr_reg = rd, rt or 31 per i_ALU_dst.
  - o_reg_write = (ALU_dst != 3) AND NOT (mem_op AND store).
- Effective valid: eff = i_valid AND NOT i_flush AND NOT squash.
- Cycle with eff=0 and no stall: captures a bubble. o_valid, o_reg_write, o_flg_mem_op and o_redirect are 0; data outputs are don't-care.
- Redirect:
  - o_redirect=1 for exactly one cycle after capturing an eff=1 taken branch or jump.
  - The same edge sets squash=1.
  - Squash clears on the next non-stalled edge, which captures the following instruction as a bubble.
- Stall (i_stall=1):
  - All EX/MEM outputs and the squash flag hold their values.
  - o_redirect is forced to 0; the redirect was already pulsed at capture.
  - Upstream holds its inputs, so nothing is lost.
- Flush and stall together: stall wins; outputs hold. A flush must be held until stall is released.
- Redirect followed by stall: squash persists through the stall and kills the first instruction consumed afterwards.
- Reset mid-stall or mid-squash: state returns to reset values immediately.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, ALU_dst=0, rd=5 -> next cycle o_alu_result=0x80000000, o_wr_reg=5, o_reg_write=1, o_valid=1.
- BEQ i_pc=0x100, A=B=3, offset=0x0004 -> o_redirect pulses once with o_redirect_pc=0x114; the next valid instruction appears with o_valid=0.
- BNE with A=B -> o_redirect=0; the next instruction passes normally.
- Store: mem_op=1, type=1, AGU op 4, src_addr=0x1000, offset=0xFFFC -> o_mem_addr=0x0FFC, o_reg_write=0, o_store_data=B.
- J taken, then i_stall held high for 3 cycles -> outputs frozen; o_redirect high only in the first cycle; after release, the first consumed instruction is a bubble.
- Assert i_rst low asynchronously between clock edges during a stall -> all outputs go to 0 without waiting for a clock edge; after release, a valid SRA A=0x80000000, B=4 gives o_alu_result=0xF8000000.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, address/branch unit and the EX/MEM register.
// Issues a one-cycle PC redirect and squashes the following wrong-path slot.
module ex_stage #(
   parameter int NBITS = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [NBITS-1:0] i_pc,
   input  logic [4:0]       i_rd,
   input  logic [4:0]       i_rt,
   input  logic [25:0]      i_addr_offset,
   input  logic             i_flg_equal,
   input  logic             i_flg_mem_op,
   input  logic             i_flg_mem_type,
   input  logic [1:0]       i_flg_mem_size,
   input  logic             i_flg_unsign,
   input  logic [1:0]       i_ALU_dst,
   input  logic [3:0]       i_ALU_opcode,
   input  logic             i_AGU_dst,
   input  logic [2:0]       i_AGU_opcode,
   input  logic             i_flg_branch,
   input  logic             i_flg_jump,
   input  logic [NBITS-1:0] i_ALU_src_A,
   input  logic [NBITS-1:0] i_ALU_src_B,
   input  logic [NBITS-1:0] i_AGU_src_addr,
   output logic             o_valid,
   output logic             o_reg_write,
   output logic [4:0]       o_wr_reg,
   output logic [NBITS-1:0] o_alu_result,
   output logic [NBITS-1:0] o_mem_addr,
   output logic [NBITS-1:0] o_store_data,
   output logic             o_flg_mem_op,
   output logic             o_flg_mem_type,
   output logic [1:0]       o_flg_mem_size,
   output logic             o_flg_unsign,
   output logic             o_AGU_dst,
   output logic             o_redirect,
   output logic [NBITS-1:0] o_redirect_pc
);

   logic [NBITS-1:0] sext16;
   logic [NBITS-1:0] alu_res;
   logic [NBITS-1:0] mem_addr;
   logic [NBITS-1:0] tgt;
   logic             taken;
   logic [4:0]       wr_reg;
   logic [4:0]       shamt;
   logic             squash;
   logic             eff;
   logic             wr_en;

   assign sext16 = {{16{i_addr_offset[15]}}, i_addr_offset[15:0]};
   assign shamt  = i_ALU_src_B[4:0];
   assign eff    = i_valid & ~i_flush & ~squash;
   assign wr_en  = (i_ALU_dst != 2'd3) &
                   ~(i_flg_mem_op & i_flg_mem_type);

   // ALU result for the current ID/EX operands
   always_comb begin
      alu_res = '0;
      case (i_ALU_opcode)
         4'd0:  alu_res = i_ALU_src_A + i_ALU_src_B;
         4'd1:  alu_res = i_ALU_src_A - i_ALU_src_B;
         4'd2:  alu_res = i_ALU_src_A & i_ALU_src_B;
         4'd3:  alu_res = i_ALU_src_A | i_ALU_src_B;
         4'd4:  alu_res = i_ALU_src_A ^ i_ALU_src_B;
         4'd5:  alu_res = ~(i_ALU_src_A | i_ALU_src_B);
         4'd6:  alu_res = {{(NBITS-1){1'b0}},
                          $signed(i_ALU_src_A) < $signed(i_ALU_src_B)};
         4'd7:  alu_res = {{(NBITS-1){1'b0}},
                          i_ALU_src_A < i_ALU_src_B};
         4'd8:  alu_res = i_ALU_src_A << shamt;
         4'd9:  alu_res = i_ALU_src_A >> shamt;
         4'd10: alu_res = $signed(i_ALU_src_A) >>> shamt;
         4'd11: alu_res = {i_ALU_src_B[15:0], 16'h0000};
         4'd12: alu_res = i_pc + 32'd8;
         default: alu_res = '0;
      endcase
   end

   // Branch/jump resolution and load/store address
   always_comb begin
      taken    = 1'b0;
      tgt      = '0;
      mem_addr = '0;
      case (i_AGU_opcode)
         3'd1: begin
            tgt = i_pc + 32'd4 + (sext16 << 2);
            if (i_flg_branch)
               taken = ((i_ALU_src_A == i_ALU_src_B) == i_flg_equal);
         end
         3'd2: begin
            tgt   = {i_pc[31:28], i_addr_offset, 2'b00};
            taken = i_flg_jump;
         end
         3'd3: begin
            tgt   = i_AGU_src_addr;
            taken = i_flg_jump;
         end
         3'd4: mem_addr = i_AGU_src_addr + sext16;
         default: ;
      endcase
   end

   // Destination register select
   always_comb begin
      wr_reg = 5'd0;
      case (i_ALU_dst)
         2'd0: wr_reg = i_rd;
         2'd1: wr_reg = i_rt;
         2'd2: wr_reg = 5'd31;
         default: wr_reg = 5'd0;
      endcase
   end

   // EX/MEM register, redirect pulse and wrong-path squash flag
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_valid        <= 1'b0;
         o_reg_write    <= 1'b0;
         o_wr_reg       <= '0;
         o_alu_result   <= '0;
         o_mem_addr     <= '0;
         o_store_data   <= '0;
         o_flg_mem_op   <= 1'b0;
         o_flg_mem_type <= 1'b0;
         o_flg_mem_size <= '0;
         o_flg_unsign   <= 1'b0;
         o_AGU_dst      <= 1'b0;
         o_redirect     <= 1'b0;
         o_redirect_pc  <= '0;
         squash         <= 1'b0;
      end else if (i_stall) begin
         o_redirect <= 1'b0;
      end else begin
         o_valid        <= eff;
         o_reg_write    <= eff & wr_en;
         o_wr_reg       <= wr_reg;
         o_alu_result   <= alu_res;
         o_mem_addr     <= mem_addr;
         o_store_data   <= i_ALU_src_B;
         o_flg_mem_op   <= eff & i_flg_mem_op;
         o_flg_mem_type <= i_flg_mem_type;
         o_flg_mem_size <= i_flg_mem_size;
         o_flg_unsign   <= i_flg_unsign;
         o_AGU_dst      <= i_AGU_dst;
         o_redirect     <= eff & taken;
         o_redirect_pc  <= tgt;
         squash         <= eff & taken;
      end
   end

endmodule
